// File: rtl/detector_borda_parametrizado.sv
// Multi-channel edge detector for push-buttons and asynchronous control inputs.
// Each channel runs through three stages:
//   1. a synchroniser chain,
//   2. a stable-count debouncer,
//   3. an edge filter selected by mode (none / press / release / both).
// The filter emits one-clock pulses toward the control unit.
module detector_borda_parametrizado #(
  parameter int NUM_CANAIS      = 4,    // independent input channels (>=1)
  parameter int SYNC_STAGES     = 2,    // synchroniser depth (>=2)
  parameter int DEBOUNCE_CYCLES = 4,    // cycles a new level must hold (>=1)
  parameter bit ATIVO_BAIXO     = 1'b1  // 1: raw 0 means pressed
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CANAIS-1:0]   sinal_entrada,
  input  logic [2*NUM_CANAIS-1:0] modo_borda,
  input  logic                    habilita,
  output logic [NUM_CANAIS-1:0]   pulso_saida,
  output logic [NUM_CANAIS-1:0]   estado_estavel
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CONT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CYCLES - 1);

  // Idle raw level: released button reads 1 when active-low, 0 otherwise.
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{ATIVO_BAIXO}};

  for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CONT_W-1:0]      cont_q;
    logic                   estavel_q;
    logic                   pulso_q;
    logic                   nivel_sync;
    logic                   diferente;
    logic                   aceita;
    logic                   casa_modo;
    logic [1:0]             modo;

    // Synchroniser chain on the raw input; only the last stage is used.
    // NOTE: the chain resets to the idle raw level, not to zero, so an
    // active-low input that sits released through reset never looks like a
    // press once reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= SYNC_IDLE;
      end else begin
        // NOTE: non-blocking assignments make every stage take its
        // neighbour's old value, which is what makes this a shift chain.
        sync_q <= {sync_q[SYNC_STAGES-2:0], sinal_entrada[i]};
      end
    end

    assign nivel_sync = sync_q[SYNC_STAGES-1] ^ ATIVO_BAIXO;
    assign diferente  = (nivel_sync != estavel_q);
    assign aceita     = diferente && (cont_q == CONT_MAX);
    assign modo       = modo_borda[2*i +: 2];

    // Mode filter evaluated against the level about to be accepted.
    always_comb begin
      casa_modo = 1'b0;
      case (modo)
        2'b01:   casa_modo = nivel_sync;
        2'b10:   casa_modo = ~nivel_sync;
        2'b11:   casa_modo = 1'b1;
        default: casa_modo = 1'b0;
      endcase
    end

    // Debouncer: count consecutive cycles that disagree with the stable
    // level; any agreeing cycle (a glitch ending) restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cont_q    <= '0;
        estavel_q <= 1'b0;
      end else if (!diferente) begin
        cont_q    <= '0;
      end else if (aceita) begin
        cont_q    <= '0;
        estavel_q <= nivel_sync;
      end else begin
        cont_q    <= cont_q + 1'b1;
      end
    end

    // Registered one-cycle pulse, issued only on the accept cycle itself so
    // later changes of habilita or modo_borda cannot create a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pulso_q <= 1'b0;
      end else begin
        pulso_q <= habilita & aceita & casa_modo;
      end
    end

    assign estado_estavel[i] = estavel_q;
    assign pulso_saida[i]    = pulso_q;
  end

endmodule

// File: tb/tb_detector_borda_parametrizado.sv
// Self-checking bench for detector_borda_parametrizado.
// Structure:
//   - a directed vector table covering the documented scenarios;
//   - a hand-written reset-abort sequence;
//   - a randomized phase compared against a sliding-window reference model.
module tb_detector_borda_parametrizado;

  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;
  localparam bit ATIVO = 1'b1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   sinal_entrada;
  logic [2*N-1:0] modo_borda;
  logic           habilita;
  logic [N-1:0]   pulso_saida;
  logic [N-1:0]   estado_estavel;

  int n_tests = 0;
  int n_fail  = 0;

  detector_borda_parametrizado #(
    .NUM_CANAIS     (N),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .ATIVO_BAIXO    (ATIVO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sinal_entrada (sinal_entrada),
    .modo_borda    (modo_borda),
    .habilita      (habilita),
    .pulso_saida   (pulso_saida),
    .estado_estavel(estado_estavel)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a raw input reaches the debouncer S edges after it is
  // sampled. A new level is accepted once the last D samples seen by the
  // debouncer all differ from the stable level.
  // ---------------------------------------------------------------------------
  bit       pipe_m [N][S];   // [0] = most recent logical raw sample
  bit       win_m  [N][D];   // [0] = most recent debouncer sample
  bit [N-1:0] m_estavel;
  bit [N-1:0] m_pulso;

  function automatic bit aceita_fn(int c);
    bit a;
    a = 1'b1;
    if (pipe_m[c][S-1] == m_estavel[c]) a = 1'b0;
    for (int d = 0; d < D - 1; d++)
      if (win_m[c][d] == m_estavel[c]) a = 1'b0;
    return a;
  endfunction

  function automatic bit casa_fn(logic [1:0] m, bit nivel);
    return (m == 2'b11) || (m == 2'b01 && nivel) || (m == 2'b10 && !nivel);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N; c++) begin
        for (int s = 0; s < S; s++) pipe_m[c][s] <= 1'b0;
        for (int d = 0; d < D; d++) win_m[c][d] <= 1'b0;
      end
      m_estavel <= '0;
      m_pulso   <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        pipe_m[c][0] <= sinal_entrada[c] ^ ATIVO;
        for (int s = 1; s < S; s++) pipe_m[c][s] <= pipe_m[c][s-1];
        win_m[c][0] <= pipe_m[c][S-1];
        for (int d = 1; d < D; d++) win_m[c][d] <= win_m[c][d-1];
        m_pulso[c] <= habilita && aceita_fn(c) &&
                      casa_fn(modo_borda[2*c +: 2], !m_estavel[c]);
        if (aceita_fn(c)) m_estavel[c] <= !m_estavel[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already set at the falling edge, outputs compared at the
  // next falling edge against the model.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("model pulso", 32'(pulso_saida), 32'(m_pulso));
    check("model estavel", 32'(estado_estavel), 32'(m_estavel));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]   raw;
    logic [2*N-1:0] modo;
    logic           hab;
    logic [N-1:0]   exp_p;
    logic [N-1:0]   exp_e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [N-1:0] raw, input logic [2*N-1:0] modo,
                     input logic hab, input logic [N-1:0] p, input logic [N-1:0] e);
    vec_t v;
    v.raw = raw; v.modo = modo; v.hab = hab; v.exp_p = p; v.exp_e = e;
    repeat (n) vecs.push_back(v);
  endtask

  logic [N-1:0] raw_r;

  initial begin
    // Idle after reset
    add(3, 4'hF, 8'h55, 1, 4'h0, 4'h0);
    // ch0 press, mode 01: pulse on the 6th row
    add(5, 4'hE, 8'h55, 1, 4'h0, 4'h0);
    add(1, 4'hE, 8'h55, 1, 4'h1, 4'h1);
    add(2, 4'hE, 8'h55, 1, 4'h0, 4'h1);
    // ch0 release, mode 01: no pulse
    add(5, 4'hF, 8'h55, 1, 4'h0, 4'h1);
    add(3, 4'hF, 8'h55, 1, 4'h0, 4'h0);
    // ch0 press, then release, in mode 11
    add(5, 4'hE, 8'h57, 1, 4'h0, 4'h0);
    add(1, 4'hE, 8'h57, 1, 4'h1, 4'h1);
    add(2, 4'hE, 8'h57, 1, 4'h0, 4'h1);
    add(5, 4'hF, 8'h57, 1, 4'h0, 4'h1);
    add(1, 4'hF, 8'h57, 1, 4'h1, 4'h0);
    add(2, 4'hF, 8'h57, 1, 4'h0, 4'h0);
    // ch1 bounce 0,1,0,0,1,0,0,... : accepted on row 10 only
    add(1, 4'hD, 8'h55, 1, 4'h0, 4'h0);
    add(1, 4'hF, 8'h55, 1, 4'h0, 4'h0);
    add(2, 4'hD, 8'h55, 1, 4'h0, 4'h0);
    add(1, 4'hF, 8'h55, 1, 4'h0, 4'h0);
    add(5, 4'hD, 8'h55, 1, 4'h0, 4'h0);
    add(1, 4'hD, 8'h55, 1, 4'h2, 4'h2);
    add(2, 4'hD, 8'h55, 1, 4'h0, 4'h2);
    add(5, 4'hF, 8'h55, 1, 4'h0, 4'h2);
    add(3, 4'hF, 8'h55, 1, 4'h0, 4'h0);
    // ch0 and ch3 together, modo C1 (ch0 = 01, ch3 = 11)
    add(5, 4'h6, 8'hC1, 1, 4'h0, 4'h0);
    add(1, 4'h6, 8'hC1, 1, 4'h9, 4'h9);
    add(2, 4'h6, 8'hC1, 1, 4'h0, 4'h9);
    add(5, 4'hF, 8'hC1, 1, 4'h0, 4'h9);
    add(1, 4'hF, 8'hC1, 1, 4'h8, 4'h0);
    add(2, 4'hF, 8'hC1, 1, 4'h0, 4'h0);
    // ch2 press with habilita = 0, then habilita raised: no late pulse
    add(5, 4'hB, 8'h55, 0, 4'h0, 4'h0);
    add(2, 4'hB, 8'h55, 0, 4'h0, 4'h4);
    add(3, 4'hB, 8'h55, 1, 4'h0, 4'h4);
    add(5, 4'hF, 8'h55, 1, 4'h0, 4'h4);
    add(3, 4'hF, 8'h55, 1, 4'h0, 4'h0);

    // Reset with idle raw inputs
    reset_n       = 1'b0;
    sinal_entrada = 4'hF;
    modo_borda    = 8'h55;
    habilita      = 1'b1;
    repeat (2) @(negedge clk);
    check("reset pulso", 32'(pulso_saida), 32'h0);
    check("reset estavel", 32'(estado_estavel), 32'h0);
    reset_n = 1'b1;

    foreach (vecs[j]) begin
      sinal_entrada = vecs[j].raw;
      modo_borda    = vecs[j].modo;
      habilita      = vecs[j].hab;
      step();
      check($sformatf("vec%0d pulso", j), 32'(pulso_saida), 32'(vecs[j].exp_p));
      check($sformatf("vec%0d estavel", j), 32'(estado_estavel), 32'(vecs[j].exp_e));
    end

    // Reset two cycles into the debounce count, input kept pressed
    sinal_entrada = 4'hE;
    modo_borda    = 8'h55;
    habilita      = 1'b1;
    repeat (4) step();
    check("pre-abort pulso", 32'(pulso_saida), 32'h0);
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("in-reset pulso", 32'(pulso_saida), 32'h0);
      check("in-reset estavel", 32'(estado_estavel), 32'h0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("post-reset pulso", 32'(pulso_saida), 32'h0);
      check("post-reset estavel", 32'(estado_estavel), 32'h0);
    end
    step();
    check("post-reset accept pulso", 32'(pulso_saida), 32'h1);
    check("post-reset accept estavel", 32'(estado_estavel), 32'h1);
    step();
    check("post-reset held pulso", 32'(pulso_saida), 32'h0);

    // Randomized phase against the reference model
    raw_r = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) raw_r[c] = ~raw_r[c];
      if (i % 16 == 0) modo_borda = 8'($urandom);
      habilita      = ($urandom_range(0, 3) != 0);
      sinal_entrada = raw_r;
      reset_n       = (i != 1500);
      step();
    end
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/detector_borda_parametrizado.md
Name: detector_borda_parametrizado

Overview:
Multi-channel, parametrised edge detector for push-buttons and other asynchronous control inputs.
Each channel has a configurable-depth synchroniser, a stable-count debouncer, and per-channel edge selection (rise, fall, both, none).
It emits one-clock pulses toward the control unit.
It replaces the fixed single-channel falling-edge detector wherever several buttons or switches feed the ALU control path.

Parameters:
NUM_CANAIS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive cycles a new synchronised level must hold before it is accepted (>=1; 1 = no filtering)
ATIVO_BAIXO, 1, 1: raw input is active-low (0 = pressed), inverted before processing; 0: active-high

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
sinal_entrada  input  NUM_CANAIS  raw asynchronous inputs, bit i = channel i
modo_borda  input  2*NUM_CANAIS  per-channel mode, bits [2i+1:2i]: 00 none, 01 press (logical rise), 10 release (logical fall), 11 both
habilita  input  1  1: pulses enabled; 0: pulses forced 0, tracking continues
pulso_saida  output  NUM_CANAIS  one-cycle pulse per accepted edge matching mode
estado_estavel  output  NUM_CANAIS  debounced logical level (1 = pressed/active)

Behaviour:
- Logical input: raw bit XOR ATIVO_BAIXO. All later logic works on the logical level.
- Reset (reset_n=0, async assert, released synchronously by the system):
  - Synchroniser FFs reset to the idle raw level (1 if ATIVO_BAIXO, else 0).
  - Debounce counters reset to 0.
  - estado_estavel resets to 0; pulso_saida resets to 0.
  - Idle inputs therefore produce no spurious pulse after reset.
- Synchroniser: SYNC_STAGES-deep shift chain per channel. Only the last stage feeds the debouncer.
- Debouncer, per channel, with counter width clog2(DEBOUNCE_CYCLES), min 1:
  - sync == estado_estavel: counter <= 0.
  - sync != estado_estavel and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != estado_estavel and counter == DEBOUNCE_CYCLES-1: estado_estavel <= sync, counter <= 0. This is the "accept" event.
  - Any glitch that returns to the stable level before acceptance clears the counter. A bounce mid-count restarts the full count.
- Latency: a clean raw step first sampled at edge k is accepted at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. estado_estavel and pulso_saida change together after that edge (registered outputs).
- Pulse generation, registered:
  - pulso_saida[i] <= habilita AND accept_i AND mode match.
  - Mode match: 01 requires the new level = 1; 10 requires the new level = 0; 11 matches either; 00 never matches.
  - The pulse is exactly one cycle wide, even when the input stays held.
  - The next pulse requires an accepted opposite transition.
- modo_borda and habilita are sampled on the same edge as the accept event. Changing them never produces a pulse by itself.
- Channels are fully independent. Simultaneous accepts on several channels yield simultaneous pulses.
- Reset asserted mid-count aborts the count with no pulse. After release, a held-pressed input is detected as a new press after the full latency.

Test Plan:
- Defaults (NUM_CANAIS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ATIVO_BAIXO=1), modo_borda=8'h55, habilita=1. Hold raw input 4'hF from reset -> pulso_saida stays 0, estado_estavel=0.
- Drive channel 0 raw 1->0 at edge k and hold -> pulso_saida=4'b0001 for exactly the cycle after edge k+5, estado_estavel[0]=1. Release 0->1 -> no pulse in mode 01; pulse in mode 11 after the same 6-edge latency.
- Drive channel 1 with bounce 0,1,0,0,1,0,0,0,0... (1-cycle glitches) -> single pulse, only after 4 consecutive stable synchronised cycles; count restarts at each glitch.
- Drive channels 0 and 3 low on the same edge with modo_borda=8'hC1 (ch0=01, ch3=11) -> pulso_saida=4'b1001 in one cycle. Release both -> 4'b1000.
- habilita=0 during a press -> no pulse but estado_estavel updates. Raise habilita afterwards -> no delayed pulse.
- Assert reset_n=0 two cycles into the debounce count, release with the input still pressed -> no pulse during or right after reset; pulse follows after the full 6-edge latency from release.
